// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and helpers for the I2S audio transmitter
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] SILENCE_OFFSET = 16'h8000;
  localparam int I2S_BITS_PER_FRAME = 64;
  localparam int I2S_BITS_PER_CH = 32;
  localparam int SLOT_W = $clog2(I2S_BITS_PER_FRAME);

  function automatic logic [SAMPLE_W-1:0] offset_to_twos(input logic [SAMPLE_W-1:0] x);
    return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
  endfunction

  // One-bit-delayed I2S: MSB in slot 1 of each channel, zero padding after the LSB.
  function automatic logic slot_bit(input logic [SLOT_W-1:0] slot,
                                    input logic [SAMPLE_W-1:0] word);
    logic [4:0] pos;
    logic [4:0] idx;
    pos = slot[4:0];
    idx = 5'd16 - pos;
    if (pos >= 5'd1 && pos <= 5'd16) begin
      return word[idx[3:0]];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// rtl/audio_i2s_tx_if.sv - sample hand-off between playback block and transmitter
interface audio_i2s_tx_if;
  import audio_pkg::*;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_strobe;

  modport master (output sample_in, input sample_strobe);
  modport slave  (input sample_in, output sample_strobe);

endinterface

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - frame counter and registered MCLK/SCLK/LRCK generation
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int MCLK_DIV   = 8,
  parameter int LRCK_RATIO = 256
) (
  input  logic              clk,
  input  logic              reset_active_high,
  input  logic              enable,
  output logic              mclk,
  output logic              sclk,
  output logic              lrck,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_end
);

  localparam int FRAME_CLKS = MCLK_DIV * LRCK_RATIO;
  localparam int BIT_CLKS   = FRAME_CLKS / I2S_BITS_PER_FRAME;
  localparam int CNT_W      = $clog2(FRAME_CLKS);
  localparam int MCLK_BIT   = $clog2(MCLK_DIV) - 1;
  localparam int SCLK_BIT   = $clog2(BIT_CLKS) - 1;

  generate
    if (MCLK_DIV < 2 || (MCLK_DIV & (MCLK_DIV - 1)) != 0) begin : g_bad_mclk_div
      $error("MCLK_DIV must be a power of 2 and at least 2");
    end
    if ((LRCK_RATIO & (LRCK_RATIO - 1)) != 0 || FRAME_CLKS < 128) begin : g_bad_lrck_ratio
      $error("LRCK_RATIO must be a power of 2 with MCLK_DIV*LRCK_RATIO >= 128");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;

  // Power-of-two frame length lets the counter wrap naturally with no gap.
  always_ff @(posedge clk) begin
    if (reset_active_high || !enable) begin
      cnt  <= '0;
      mclk <= 1'b0;
      sclk <= 1'b0;
      lrck <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      mclk <= cnt[MCLK_BIT];
      sclk <= cnt[SCLK_BIT];
      lrck <= cnt[CNT_W-1];
    end
  end

  assign slot      = cnt[CNT_W-1 -: SLOT_W];
  assign frame_end = &cnt;

endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - mono offset-binary sample to stereo I2S DAC transmitter
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int MCLK_DIV   = 8,
  parameter int LRCK_RATIO = 256
) (
  input  logic           clk,
  input  logic           reset_active_high,
  input  logic           enable,
  input  logic           mute,
  audio_i2s_tx_if.slave  src,
  output logic           i2s_mclk,
  output logic           i2s_sclk,
  output logic           i2s_lrck,
  output logic           i2s_sdata
);

  logic [SLOT_W-1:0]   slot;
  logic                frame_end;
  logic [SAMPLE_W-1:0] tx_word;
  logic                strobe_q;

  i2s_clkgen #(
    .MCLK_DIV   (MCLK_DIV),
    .LRCK_RATIO (LRCK_RATIO)
  ) u_clkgen (
    .clk               (clk),
    .reset_active_high (reset_active_high),
    .enable            (enable),
    .mclk              (i2s_mclk),
    .sclk              (i2s_sclk),
    .lrck              (i2s_lrck),
    .slot              (slot),
    .frame_end         (frame_end)
  );

  // The word is latched once per frame so both channels always carry the same sample.
  always_ff @(posedge clk) begin
    if (reset_active_high || !enable) begin
      tx_word   <= '0;
      strobe_q  <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      strobe_q  <= frame_end;
      i2s_sdata <= slot_bit(slot, tx_word);
      if (frame_end) begin
        tx_word <= mute ? '0 : offset_to_twos(src.sample_in);
      end
    end
  end

  assign src.sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - self-checking bench for audio_i2s_tx
module tb_audio_i2s_tx;
  import audio_pkg::*;

  localparam int FRAME = 2048;
  localparam int NVEC  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic mute = 1'b0;
  logic mclk, sclk, lrck, sdata;

  audio_i2s_tx_if bus();

  audio_i2s_tx #(
    .MCLK_DIV   (8),
    .LRCK_RATIO (256)
  ) dut (
    .clk               (clk),
    .reset_active_high (rst),
    .enable            (enable),
    .mute              (mute),
    .src               (bus.slave),
    .i2s_mclk          (mclk),
    .i2s_sclk          (sclk),
    .i2s_lrck          (lrck),
    .i2s_sdata         (sdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sample;
    logic        mute;
    int          pos;
    logic [15:0] exp_tx;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [63:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          e = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    #1;
  endtask

  function automatic logic [63:0] frame_pat(input logic [15:0] w);
    return {1'b0, w, 15'd0, 1'b0, w, 15'd0};
  endfunction

  task automatic check_restart(input string name);
    int first_stb;
    int first_mclk;
    first_stb  = -1;
    first_mclk = -1;
    for (int i = 0; i < 2100 && first_stb < 0; i++) begin
      step();
      if (first_mclk < 0 && mclk === 1'b1) first_mclk = e;
      if (bus.sample_strobe === 1'b1) first_stb = e;
    end
    chk({name, "_first_mclk_rise"}, 64'(first_mclk), 64'd4);
    chk({name, "_first_strobe"}, 64'(first_stb), 64'd2047);
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] exp_pat;
    logic        prev_sd;
    logic [10:0] pv;
    int clk_err, stable_err, stb_cnt, stb_pos;
    int first_mclk, first_sclk, first_lrck, last_stb;

    vecs[0] = '{16'h8000, 1'b0, 0,   16'h0000};
    vecs[1] = '{16'h8000, 1'b0, 0,   16'h0000};
    vecs[2] = '{16'h8000, 1'b0, 0,   16'h0000};
    vecs[3] = '{16'hFFFF, 1'b0, 0,   16'h7FFF};
    vecs[4] = '{16'h0000, 1'b0, 0,   16'h8000};
    vecs[5] = '{16'hC000, 1'b0, 999, 16'h4000};
    vecs[6] = '{16'hFFFF, 1'b0, 0,   16'h7FFF};
    vecs[7] = '{16'hFFFF, 1'b1, 499, 16'h0000};
    vecs[8] = '{16'h1234, 1'b1, 0,   16'h0000};
    vecs[9] = '{16'h1234, 1'b0, 0,   16'h9234};

    bus.sample_in = SILENCE_OFFSET;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_outputs", 64'({mclk, sclk, lrck, sdata, bus.sample_strobe}), 64'd0);
    end
    rst = 1'b0;
    e = -1;

    first_mclk = -1;
    first_sclk = -1;
    first_lrck = -1;
    last_stb   = -1;
    exp_q.push_back(frame_pat(16'h0000));
    prev_sd = 1'b0;

    for (int f = 0; f <= NVEC; f++) begin
      got = '0;
      clk_err = 0;
      stable_err = 0;
      stb_cnt = 0;
      stb_pos = -1;
      for (int p = 0; p < FRAME; p++) begin
        step();
        if (f < NVEC && p == vecs[f].pos) begin
          bus.sample_in = vecs[f].sample;
          mute = vecs[f].mute;
          exp_q.push_back(frame_pat(vecs[f].exp_tx));
        end
        pv = p[10:0];
        if (mclk !== pv[2] || sclk !== pv[4] || lrck !== pv[10]) clk_err++;
        if (p % 32 == 16) got[63 - p / 32] = sdata;
        if (sdata !== prev_sd && p % 32 != 0) stable_err++;
        prev_sd = sdata;
        if (bus.sample_strobe === 1'b1) begin
          stb_cnt++;
          stb_pos = p;
          if (last_stb >= 0) chk("strobe_spacing", 64'(e - last_stb), 64'(FRAME));
          last_stb = e;
        end
        if (f == 0) begin
          if (first_mclk < 0 && mclk === 1'b1) first_mclk = e;
          if (first_sclk < 0 && sclk === 1'b1) first_sclk = e;
          if (first_lrck < 0 && lrck === 1'b1) first_lrck = e;
        end
      end
      if (f == 0) begin
        chk("first_mclk_rise", 64'(first_mclk), 64'd4);
        chk("first_sclk_rise", 64'(first_sclk), 64'd16);
        chk("first_lrck_rise", 64'(first_lrck), 64'd1024);
      end
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        exp_pat = exp_q.pop_front();
        chk($sformatf("frame%0d_sdata", f), got, exp_pat);
      end
      chk($sformatf("frame%0d_clocks_err", f), 64'(clk_err), 64'd0);
      chk($sformatf("frame%0d_sdata_stable_err", f), 64'(stable_err), 64'd0);
      chk($sformatf("frame%0d_strobe_count", f), 64'(stb_cnt), 64'd1);
      chk($sformatf("frame%0d_strobe_pos", f), 64'(stb_pos), 64'd2047);
    end

    for (int p = 0; p < 1000; p++) step();
    rst = 1'b1;
    step();
    chk("midreset_outputs", 64'({mclk, sclk, lrck, sdata, bus.sample_strobe}), 64'd0);
    step();
    step();
    rst = 1'b0;
    e = -1;
    check_restart("after_reset");

    for (int p = 0; p < 700; p++) step();
    enable = 1'b0;
    step();
    chk("disable_outputs", 64'({mclk, sclk, lrck, sdata, bus.sample_strobe}), 64'd0);
    step();
    enable = 1'b1;
    e = -1;
    check_restart("after_enable");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
